store_size_rmw: RTL and testbench
=================================

// Module: store_size_rmw
// PURPOSE
//  Store-side counterpart of the load-size unit. Sub-word stores (byte/half) need a
//  read-modify-write (RMW) of the addressed 32-bit memory word. This block sequences
//  that RMW: read the old word, merge the register data into the selected lane, write back.
//  Sits between the control unit (start/done handshake), B-register data and the data memory.
// PARAMETERS
//  MEM_RD_LAT  1  data-memory read latency in cycles (legal range 1..7)
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  reset_n     in   1   synchronous active-low reset
//  start       in   1   one-cycle request; sampled only in IDLE
//  store_size  in   2   11=byte, 10=half, 01=word, 00=no-op (same encoding as load side)
//  addr_lo     in   2   byte offset of the target address; used only with lane select enabled
//  rs_data     in   32  register data to store
//  mem_rdata   in   32  data-memory read data, valid MEM_RD_LAT cycles after mem_rd
//  busy        out  1   high in every state except IDLE
//  done        out  1   one-cycle completion pulse
//  mem_rd      out  1   memory read strobe, one cycle
//  mem_wr      out  1   memory write strobe, one cycle
//  mem_wdata   out  32  registered write data; held stable while mem_wr=1
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge): state=IDLE; busy, done, mem_rd, mem_wr = 0;
//   mem_wdata, old-word reg, size/offset/data capture regs = 0. Reset mid-RMW aborts
//   immediately; a pending write is never issued.
//  On start in IDLE: capture store_size, addr_lo and rs_data. These inputs are don't-care after capture.
//  States (Moore outputs are decoded from state):
//   IDLE : if start=1 and size=01 -> WR, with mem_wdata<=rs_data
//          if start=1 and size=11/10 -> RD
//          if start=1 and size=00 -> DONE (no memory access)
//   RD   : mem_rd=1 -> WAIT, wait counter cleared
//   WAIT : stays MEM_RD_LAT cycles; on last cycle old<=mem_rdata, mem_wdata<=merge -> WR
//   WR   : mem_wr=1 -> DONE
//   DONE : done=1 -> IDLE
//  Merge rule without the optional feature (lane 0, mirrors load side):
//   byte -> {old[31:8], d[7:0]}
//   half -> {old[31:16], d[15:0]}
//  Latency from start at cycle T:
//   word: mem_wr at T+1, done at T+2
//   no-op: done at T+1
//   byte/half: mem_rd at T+1, mem_wr at T+2+MEM_RD_LAT, done at T+3+MEM_RD_LAT
//  start while busy=1 is ignored: not queued, no effect on captured values.
//  start asserted in the same cycle as done is also ignored, because state is DONE, not IDLE.
//  mem_rd and mem_wr are never high in the same cycle. Neither is high in IDLE.
//  Wait counter width is 3 bits and saturates at MEM_RD_LAT-1; it must not wrap.
// CONFIGURATION
//  STORE_SIZE_LANE_SEL_EN defined:
//   byte goes to lane addr_lo: bits [8*addr_lo+7 : 8*addr_lo] = d[7:0]; all other bits keep old.
//   half goes to lane addr_lo[1]: [31:16] if 1, else [15:0]. addr_lo[0] is ignored for half.
//   word ignores addr_lo.
//  Not defined: addr_lo is unused and all sub-word stores go to lane 0 as described above.
// TESTING
//  1 word: start, size=01, d=0xDEADBEEF -> mem_wr at T+1 with wdata 0xDEADBEEF, done T+2, mem_rd never high
//  2 byte LAT=1: old=0x11223344, d=0xAABBCCDD -> mem_rd T+1, mem_wr T+3 with wdata 0x112233DD, done T+4
//  3 half LAT=3: old=0x11223344, d=0x0000BEEF -> mem_wr T+5 with wdata 0x1122BEEF, done T+6
//  4 no-op / busy start: size=00 -> done T+1, no mem strobe; start pulsed during WAIT -> ignored,
//    exactly one done
//  5 reset: reset_n=0 during WAIT -> next cycle IDLE with busy=0; mem_wr never asserted;
//    a new word store then completes normally
//  6 LANE_SEL_EN: byte, addr_lo=2, old=0x11223344, d=0xAA -> 0x11AA3344;
//    half, addr_lo=3, d=0xBEEF -> 0xBEEF3344

Source files
------------

// File: rtl/store_size_rmw.sv
// store_size_rmw: sequences the read-modify-write of a 32-bit memory word for sub-word
// stores. Full-word stores are written directly. A no-op size completes without touching
// memory.
//
// Parameters:
//   MEM_RD_LAT  data-memory read latency in cycles (1..7)
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     synchronous active-low reset
//   start       one-cycle request, accepted only when idle
//   store_size  11=byte, 10=half, 01=word, 00=no-op
//   addr_lo     byte offset of the target address (lane select build only)
//   rs_data     register data to store
//   mem_rdata   memory read data, valid MEM_RD_LAT cycles after mem_rd
//   busy        high whenever not idle
//   done        one-cycle completion pulse
//   mem_rd      one-cycle memory read strobe
//   mem_wr      one-cycle memory write strobe
//   mem_wdata   registered write data, stable while mem_wr is high
//
// Build option:
//   STORE_SIZE_LANE_SEL_EN  byte/half stores go to the lane chosen by addr_lo;
//                           otherwise every sub-word store goes to lane 0.

module store_size_rmw #(
  parameter int unsigned MEM_RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  store_size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs_data,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_wdata
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned CNT_W  = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_RD_LAT - 1);

  localparam logic [1:0] SZ_NOP  = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   wait_cnt_q;
  logic               is_byte_q;
  logic [HALF_W-1:0]  data_q;
  logic [DATA_W-1:0]  merged_c;

`ifdef STORE_SIZE_LANE_SEL_EN
  logic [1:0] lo_q;

  // Insert the byte/half into the lane picked by the captured offset.
  function automatic logic [DATA_W-1:0] merge_lane(
    input logic [DATA_W-1:0] old_word,
    input logic [HALF_W-1:0] d,
    input logic              is_byte,
    input logic [1:0]        lo
  );
    logic [DATA_W-1:0] w;
    w = old_word;
    if (is_byte) begin
      case (lo)
        2'd0:    w[7:0]   = d[7:0];
        2'd1:    w[15:8]  = d[7:0];
        2'd2:    w[23:16] = d[7:0];
        default: w[31:24] = d[7:0];
      endcase
    end else if (lo[1]) begin
      w[31:16] = d;
    end else begin
      w[15:0] = d;
    end
    return w;
  endfunction

  assign merged_c = merge_lane(mem_rdata, data_q, is_byte_q, lo_q);
`else
  logic unused_addr_lo;

  // Lane 0 only: low byte or low half replaced, upper bits kept from memory.
  function automatic logic [DATA_W-1:0] merge_lane0(
    input logic [DATA_W-1:0] old_word,
    input logic [HALF_W-1:0] d,
    input logic              is_byte
  );
    logic [DATA_W-1:0] w;
    w = old_word;
    if (is_byte) w[7:0] = d[7:0];
    else         w[15:0] = d;
    return w;
  endfunction

  assign unused_addr_lo = ^addr_lo;
  assign merged_c       = merge_lane0(mem_rdata, data_q, is_byte_q);
`endif

  // State sequencing with registered outputs set on each transition.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      is_byte_q  <= 1'b0;
      data_q     <= '0;
`ifdef STORE_SIZE_LANE_SEL_EN
      lo_q       <= '0;
`endif
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      done   <= 1'b0;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            is_byte_q <= store_size[0];
            data_q    <= rs_data[HALF_W-1:0];
`ifdef STORE_SIZE_LANE_SEL_EN
            lo_q      <= addr_lo;
`endif
            busy      <= 1'b1;
            if (store_size == SZ_WORD) begin
              state_q   <= S_WR;
              mem_wr    <= 1'b1;
              mem_wdata <= rs_data;
            end else if (store_size == SZ_NOP) begin
              state_q <= S_DONE;
              done    <= 1'b1;
            end else begin
              state_q <= S_RD;
              mem_rd  <= 1'b1;
            end
          end
        end
        S_RD: begin
          state_q    <= S_WAIT;
          wait_cnt_q <= '0;
        end
        S_WAIT: begin
          // Counter stops at the last wait cycle, so it never wraps.
          if (wait_cnt_q == CNT_LAST) begin
            state_q   <= S_WR;
            mem_wr    <= 1'b1;
            mem_wdata <= merged_c;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end
        S_WR: begin
          state_q <= S_DONE;
          done    <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_size_rmw.sv
// Bench for store_size_rmw: two instances (read latency 1 and 3) share stimulus; a
// scoreboard of expected strobe events (kind, cycle, write data) is filled when a request
// is driven and drained by a per-instance monitor on the falling edge.

module tb_store_size_rmw;

  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;
  localparam int EV_RD = 0;
  localparam int EV_WR = 1;
  localparam int EV_DN = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  store_size;
  logic [1:0]  addr_lo;
  logic [31:0] rs_data;
  logic [31:0] old_word;

  logic        busy_a, done_a, rd_a, wr_a;
  logic [31:0] wd_a, rdata_a;
  logic        busy_b, done_b, rd_b, wr_b;
  logic [31:0] wd_b, rdata_b;
  logic [7:0]  hist_a = '0;
  logic [7:0]  hist_b = '0;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic mon_en = 1'b0;
  int st[2];
  int en[2];

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] wd;
  } ev_t;
  ev_t q0[$];
  ev_t q1[$];

  typedef struct {
    logic [1:0]  size;
    logic [1:0]  lo;
    logic [31:0] d;
    logic [31:0] old;
    logic [31:0] exp_lane0;
    logic [31:0] exp_lanesel;
  } vec_t;
  vec_t vecs[11];

  store_size_rmw #(.MEM_RD_LAT(1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .start(start), .store_size(store_size),
    .addr_lo(addr_lo), .rs_data(rs_data), .mem_rdata(rdata_a),
    .busy(busy_a), .done(done_a), .mem_rd(rd_a), .mem_wr(wr_a), .mem_wdata(wd_a)
  );

  store_size_rmw #(.MEM_RD_LAT(3)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .store_size(store_size),
    .addr_lo(addr_lo), .rs_data(rs_data), .mem_rdata(rdata_b),
    .busy(busy_b), .done(done_b), .mem_rd(rd_b), .mem_wr(wr_b), .mem_wdata(wd_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data is valid only in the one cycle it is due.
  always @(posedge clk) begin
    hist_a <= {hist_a[6:0], rd_a};
    hist_b <= {hist_b[6:0], rd_b};
  end
  assign rdata_a = hist_a[0] ? old_word : JUNK;
  assign rdata_b = hist_b[2] ? old_word : JUNK;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cyc %0d: got %h expected %h", nm, i, cyc, act, exp);
    end
  endtask

  task automatic push_ev(input int i, input int kind, input int c, input logic [31:0] w);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.wd   = w;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Expected events for a request accepted at cycle t.
  task automatic expect_store(input int t, input logic [1:0] sz, input logic [31:0] w);
    for (int i = 0; i < 2; i++) begin
      int lat;
      lat = (i == 0) ? 1 : 3;
      st[i] = t;
      case (sz)
        2'b01: begin
          push_ev(i, EV_WR, t + 1, w);
          push_ev(i, EV_DN, t + 2, 32'h0);
          en[i] = t + 2;
        end
        2'b00: begin
          push_ev(i, EV_DN, t + 1, 32'h0);
          en[i] = t + 1;
        end
        default: begin
          push_ev(i, EV_RD, t + 1, 32'h0);
          push_ev(i, EV_WR, t + 2 + lat, w);
          push_ev(i, EV_DN, t + 3 + lat, 32'h0);
          en[i] = t + 3 + lat;
        end
      endcase
    end
  endtask

  task automatic take(input int i, input int kind, input logic [31:0] wd);
    ev_t e;
    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_strobe inst%0d cyc %0d: got kind %0d expected none", i, cyc, kind);
    end else begin
      if (i == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk("event_kind", i, 32'(kind), 32'(e.kind));
      chk("event_cycle", i, 32'(cyc), 32'(e.cyc));
      if (kind == EV_WR) chk("mem_wdata", i, wd, e.wd);
    end
  endtask

  task automatic mon(input int i, input logic b, input logic rd, input logic wr,
                     input logic dn, input logic [31:0] wd);
    logic eb;
    eb = (cyc > st[i]) && (cyc <= en[i]);
    chk("busy", i, 32'(b), 32'(eb));
    chk("rd_wr_exclusive", i, 32'(rd & wr), 32'h0);
    if (rd) take(i, EV_RD, wd);
    if (wr) take(i, EV_WR, wd);
    if (dn) take(i, EV_DN, wd);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, busy_a, rd_a, wr_a, done_a, wd_a);
      mon(1, busy_b, rd_b, wr_b, done_b, wd_b);
    end
  end

  task automatic drain_check();
    chk("queue_drained", 0, 32'(q0.size()), 32'h0);
    chk("queue_drained", 1, 32'(q1.size()), 32'h0);
  endtask

  // Drive one request, scramble inputs afterwards, then let both instances finish.
  task automatic do_store(input logic [1:0] sz, input logic [1:0] lo, input logic [31:0] d,
                          input logic [31:0] old, input logic [31:0] w);
    old_word   = old;
    start      = 1'b1;
    store_size = sz;
    addr_lo    = lo;
    rs_data    = d;
    expect_store(cyc, sz, w);
    @(posedge clk); #1;
    start      = 1'b0;
    store_size = 2'($urandom);
    addr_lo    = 2'($urandom);
    rs_data    = $urandom;
    repeat (10) @(posedge clk);
    #1;
    drain_check();
  endtask

  function automatic logic [31:0] pick(input vec_t v);
`ifdef STORE_SIZE_LANE_SEL_EN
    return v.exp_lanesel;
`else
    return v.exp_lane0;
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset_n    = 1'b0;
    start      = 1'b0;
    store_size = 2'b00;
    addr_lo    = 2'b00;
    rs_data    = 32'h0;
    old_word   = 32'h0;
    st = '{0, 0};
    en = '{0, 0};

    vecs[0]  = '{2'b01, 2'd0, 32'hDEADBEEF, 32'h11223344, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1]  = '{2'b11, 2'd0, 32'hAABBCCDD, 32'h11223344, 32'h112233DD, 32'h112233DD};
    vecs[2]  = '{2'b10, 2'd0, 32'h0000BEEF, 32'h11223344, 32'h1122BEEF, 32'h1122BEEF};
    vecs[3]  = '{2'b00, 2'd1, 32'h12345678, 32'h11223344, 32'h0,        32'h0};
    vecs[4]  = '{2'b11, 2'd2, 32'h000000AA, 32'h11223344, 32'h112233AA, 32'h11AA3344};
    vecs[5]  = '{2'b10, 2'd3, 32'h0000BEEF, 32'h11223344, 32'h1122BEEF, 32'hBEEF3344};
    vecs[6]  = '{2'b11, 2'd1, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFF78, 32'hFFFF78FF};
    vecs[7]  = '{2'b11, 2'd3, 32'h000000A5, 32'h00000000, 32'h000000A5, 32'hA5000000};
    vecs[8]  = '{2'b10, 2'd1, 32'hCAFEF00D, 32'h89ABCDEF, 32'h89ABF00D, 32'h89ABF00D};
    vecs[9]  = '{2'b01, 2'd3, 32'h01234567, 32'hFFFFFFFF, 32'h01234567, 32'h01234567};
    vecs[10] = '{2'b10, 2'd2, 32'hFFFF1234, 32'h00000000, 32'h00001234, 32'h12340000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 0, 32'(busy_a), 32'h0);
    chk("reset_done", 0, 32'(done_a), 32'h0);
    chk("reset_rd", 0, 32'(rd_a), 32'h0);
    chk("reset_wr", 0, 32'(wr_a), 32'h0);
    chk("reset_wdata", 0, wd_a, 32'h0);
    chk("reset_busy", 1, 32'(busy_b), 32'h0);
    chk("reset_done", 1, 32'(done_b), 32'h0);
    chk("reset_rd", 1, 32'(rd_b), 32'h0);
    chk("reset_wr", 1, 32'(wr_b), 32'h0);
    chk("reset_wdata", 1, wd_b, 32'h0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[k]) do_store(vecs[k].size, vecs[k].lo, vecs[k].d, vecs[k].old, pick(vecs[k]));

    // Starts while busy (during WAIT, and on the latency-1 instance's done cycle) are ignored.
    old_word   = 32'h11223344;
    start      = 1'b1;
    store_size = 2'b11;
    addr_lo    = 2'd0;
    rs_data    = 32'hAABBCCDD;
    t = cyc;
    expect_store(t, 2'b11, 32'h112233DD);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start      = 1'b1;
    store_size = 2'b01;
    rs_data    = 32'hFFFFFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start      = 1'b1;
    store_size = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    drain_check();

    // Reset during WAIT aborts; no write is ever issued.
    old_word   = 32'h55667788;
    start      = 1'b1;
    store_size = 2'b11;
    addr_lo    = 2'd0;
    rs_data    = 32'h000000EE;
    t = cyc;
    for (int i = 0; i < 2; i++) begin
      push_ev(i, EV_RD, t + 1, 32'h0);
      st[i] = t;
      en[i] = t + 2;
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("abort_busy", 0, 32'(busy_a), 32'h0);
    chk("abort_busy", 1, 32'(busy_b), 32'h0);
    chk("abort_wdata", 0, wd_a, 32'h0);
    chk("abort_wdata", 1, wd_b, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    drain_check();
    do_store(2'b01, 2'd0, 32'hC0FFEE11, 32'h0, 32'hC0FFEE11);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
